// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 shared constants, schedule state encoding and sigma helpers
package sha256_pkg;

    // RAM word map: H constants, then K constants, then the W schedule
    localparam int H_BASE = 0;
    localparam int K_BASE = 8;
    localparam int W_BASE = 72;

    localparam int N_BLOCK_WORDS = 16;
    localparam int N_EXP_WORDS   = 48;
    localparam int N_SCHED_WORDS = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } msgsched_state_e;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/mod_msgsched_if.sv
// rtl/mod_msgsched_if.sv - message-schedule control and RAM bus; MOD_MSGSCHED_WOUT_EN adds the W stream
interface mod_msgsched_if #(
    parameter int ADDR_W = 8
);
    logic              mem_ready;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
`ifdef MOD_MSGSCHED_WOUT_EN
    logic [31:0]       w_out;
    logic              w_valid;
    logic [5:0]        w_idx;
`endif

    modport master (
        input  mem_ready, start, ram_dout,
        output busy, done, ram_addr, ram_re, ram_we, ram_din
`ifdef MOD_MSGSCHED_WOUT_EN
        , output w_out, w_valid, w_idx
`endif
    );

    modport slave (
        output mem_ready, start, ram_dout,
        input  busy, done, ram_addr, ram_re, ram_we, ram_din
`ifdef MOD_MSGSCHED_WOUT_EN
        , input w_out, w_valid, w_idx
`endif
    );

endinterface

// File: rtl/mod_msgsched_sigma.sv
// rtl/mod_msgsched_sigma.sv - combinational sigma0/sigma1 pair and four-operand schedule adder
module msgsched_sigma
    import sha256_pkg::*;
(
    input  logic [31:0] w_m16,
    input  logic [31:0] w_m15,
    input  logic [31:0] w_m7,
    input  logic [31:0] w_m2,
    output logic [31:0] w_new
);

    // W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], carries discarded
    assign w_new = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16;

endmodule

// File: rtl/mod_msgsched.sv
// rtl/mod_msgsched.sv - SHA-256 message schedule: load 16 words, expand and write back W[16..63]; MOD_MSGSCHED_WOUT_EN streams W
module mod_msgsched
    import sha256_pkg::*;
#(
    parameter int W_BASE = sha256_pkg::W_BASE,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mod_msgsched_if.master bus
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_LOAD   = ST_LOAD;
    localparam logic [1:0] S_EXPAND = ST_EXPAND;
    localparam logic [1:0] S_DONE   = ST_DONE;

    localparam logic [ADDR_W-1:0] ADDR_BLOCK = ADDR_W'(W_BASE);
    localparam logic [ADDR_W-1:0] ADDR_EXP   = ADDR_W'(W_BASE + N_BLOCK_WORDS);
    localparam logic [5:0]        LOAD_LAST  = 6'(N_BLOCK_WORDS);
    localparam logic [5:0]        EXP_LAST   = 6'(N_EXP_WORDS - 1);

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] win [16];
    logic        shift_en;
    logic [31:0] shift_word;
    logic [31:0] w_next;

    // RAM outputs are registered, so the word written in a cycle is computed
    // one edge earlier from the window before that edge's shift: indices
    // 1/2/10/15 pre-shift are W[t-16]/W[t-15]/W[t-7]/W[t-2] of the next word.
    msgsched_sigma u_sigma (
        .w_m16 (win[1]),
        .w_m15 (win[2]),
        .w_m7  (win[10]),
        .w_m2  (win[15]),
        .w_new (w_next)
    );

    // Word entering the window this cycle: read data in LOAD, written word in EXPAND
    always_comb begin
        shift_en   = 1'b0;
        shift_word = 32'h0;
        if (state == S_LOAD && cnt != 6'd0) begin
            shift_en   = 1'b1;
            shift_word = bus.ram_dout;
        end else if (state == S_EXPAND) begin
            shift_en   = 1'b1;
            shift_word = bus.ram_din;
        end
    end

    // 16-word sliding window, index 0 oldest
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) win[i] <= 32'h0;
        end else if (shift_en) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= shift_word;
        end
    end

    // Sequencer and registered RAM/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 6'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.ram_re   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && bus.mem_ready) begin
                        state        <= S_LOAD;
                        cnt          <= 6'd0;
                        bus.busy     <= 1'b1;
                        bus.ram_re   <= 1'b1;
                        bus.ram_addr <= ADDR_BLOCK;
                    end
                end
                S_LOAD: begin
                    if (cnt == LOAD_LAST) begin
                        state        <= S_EXPAND;
                        cnt          <= 6'd0;
                        bus.ram_re   <= 1'b0;
                        bus.ram_we   <= 1'b1;
                        bus.ram_addr <= ADDR_EXP;
                        bus.ram_din  <= w_next;
                    end else begin
                        cnt          <= cnt + 6'd1;
                        bus.ram_re   <= (cnt < LOAD_LAST - 6'd1);
                        bus.ram_addr <= ADDR_BLOCK + ADDR_W'(cnt + 6'd1);
                    end
                end
                S_EXPAND: begin
                    if (cnt == EXP_LAST) begin
                        state      <= S_DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.ram_we <= 1'b0;
                    end else begin
                        cnt          <= cnt + 6'd1;
                        bus.ram_addr <= bus.ram_addr + ADDR_W'(1);
                        bus.ram_din  <= w_next;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MOD_MSGSCHED_WOUT_EN
    // Every W word is presented the cycle it enters the window
    always_comb begin
        bus.w_valid = shift_en;
        bus.w_out   = shift_en ? shift_word : 32'h0;
        bus.w_idx   = 6'd0;
        if (state == S_LOAD && cnt != 6'd0) bus.w_idx = cnt - 6'd1;
        else if (state == S_EXPAND)         bus.w_idx = cnt + 6'(N_BLOCK_WORDS);
    end
`endif

endmodule

// File: tb/tb_mod_msgsched.sv
// tb/tb_mod_msgsched.sv - directed self-checking bench for mod_msgsched
module tb_mod_msgsched;

    localparam int WB = 72;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_msgsched_if #(.ADDR_W(8)) bus ();

    mod_msgsched #(.W_BASE(WB), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [256];
    logic [31:0] ref_w [64];
    int vectors = 0;
    int errs    = 0;
    int wr_count = 0;
    int rd_count = 0;
    int both_hi  = 0;
    int stray_wr = 0;

    // RAM model: one-cycle read latency, full-word writes
    always @(posedge clk) begin
        if (bus.ram_re) begin
            bus.ram_dout <= mem[bus.ram_addr];
            rd_count++;
        end
        if (bus.ram_we) begin
            mem[bus.ram_addr] = bus.ram_din;
            wr_count++;
            if (bus.ram_addr < 8'(WB + 16) || bus.ram_addr > 8'(WB + 63)) stray_wr++;
        end
        if (bus.ram_re && bus.ram_we) both_hi++;
    end

`ifdef MOD_MSGSCHED_WOUT_EN
    int wv_count = 0;
    int wv_err   = 0;
    always @(negedge clk) begin
        if (bus.w_valid) begin
            if (bus.w_idx != 6'(wv_count) || bus.w_out !== ref_w[bus.w_idx]) wv_err++;
            wv_count++;
        end
    end
`endif

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic build_ref();
        for (int i = 0; i < 16; i++) ref_w[i] = mem[WB + i];
        for (int t = 16; t < 64; t++)
            ref_w[t] = m_s1(ref_w[t-2]) + ref_w[t-7] + m_s0(ref_w[t-15]) + ref_w[t-16];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int wr0, rd0, busy_seen, bad, lat, found;
        logic [31:0] pat;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < WB; i++) mem[i] = 32'hC0DE0000 + 32'(i);

        // Reset state
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_re", {31'b0, bus.ram_re}, 32'h0);
        check("rst_we", {31'b0, bus.ram_we}, 32'h0);
        check("rst_addr", {24'b0, bus.ram_addr}, 32'h0);
        check("rst_din", bus.ram_din, 32'h0);
        rst = 1'b0;

        // START while MEM_READY low is dropped, not queued
        wr0 = wr_count;
        rd0 = rd_count;
        busy_seen = 0;
        bus.start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 50) bus.mem_ready = 1'b1;
            if (bus.busy) busy_seen++;
        end
        check("gate_busy", 32'(busy_seen), 32'h0);
        check("gate_reads", 32'(rd_count - rd0), 32'h0);
        check("gate_writes", 32'(wr_count - wr0), 32'h0);

        // "abc" block, START held high the whole time it is busy and in DONE
        mem[WB] = 32'h61626380;
        for (int i = 1; i < 15; i++) mem[WB + i] = 32'h0;
        mem[WB + 15] = 32'h00000018;
        build_ref();
`ifdef MOD_MSGSCHED_WOUT_EN
        wv_count = 0;
        wv_err   = 0;
`endif
        wr0 = wr_count;
        bus.start = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            check($sformatf("abc_busy_c%0d", k), {31'b0, bus.busy}, {31'b0, (k >= 1 && k <= 65)});
            check($sformatf("abc_done_c%0d", k), {31'b0, bus.done}, {31'b0, (k == 66)});
            if (k == 66) bus.start = 1'b0;
        end
        check("abc_w16", mem[88], 32'h61626380);
        check("abc_w17", mem[89], 32'h000F0000);
        check("abc_w18", mem[90], 32'h7DA86405);
        for (int t = 16; t < 64; t++) check($sformatf("abc_w%0d", t), mem[WB + t], ref_w[t]);
        check("abc_writes", 32'(wr_count - wr0), 32'd48);
        bad = 0;
        for (int i = 0; i < WB; i++) if (mem[i] !== 32'hC0DE0000 + 32'(i)) bad++;
        check("const_intact", 32'(bad), 32'h0);
        check("stray_writes", 32'(stray_wr), 32'h0);
`ifdef MOD_MSGSCHED_WOUT_EN
        check("wout_count", 32'(wv_count), 32'd64);
        check("wout_errors", 32'(wv_err), 32'h0);
`endif

        // Second block; MEM_READY falls mid-operation without effect
        for (int i = 0; i < 16; i++) begin
            pat = 32'h9E3779B9 * 32'(i + 1);
            mem[WB + i] = pat ^ 32'h0BADF00D;
        end
        for (int i = 16; i < 64; i++) mem[WB + i] = 32'h0;
        build_ref();
        bus.start = 1'b1;
        lat = 0;
        found = 0;
        for (int k = 1; k <= 100 && found == 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 10) bus.mem_ready = 1'b0;
            if (bus.done) begin
                found = 1;
                lat = k;
            end
        end
        check("pat_latency", 32'(lat), 32'd66);
        for (int t = 16; t < 64; t++) check($sformatf("pat_w%0d", t), mem[WB + t], ref_w[t]);
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of EXPAND
        bus.start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("mid_busy_before", {31'b0, bus.busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
        check("mid_rst_done", {31'b0, bus.done}, 32'h0);
        check("mid_rst_we", {31'b0, bus.ram_we}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr0 = wr_count;
        busy_seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.busy || bus.done) busy_seen++;
        end
        check("mid_idle_after", 32'(busy_seen), 32'h0);
        check("mid_no_writes", 32'(wr_count - wr0), 32'h0);
        check("never_re_and_we", 32'(both_hi), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
